// File: rtl/uart_pkg.sv
// Shared definitions for the odd-parity UART transmitter and receiver pair.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Parity bit that makes data+parity carry an odd number of ones.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: pulses bit_end on the last clock of every CLKS_PER_BIT window.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || cnt_q == LAST) cnt_d = '0;
    else                          cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bit_end = !restart && (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_odd_parity.sv
// Odd-parity serial frame transmitter: start, 8 data bits LSB first, parity, stop.
module uart_tx_odd_parity
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out,
  output logic       busy
);
  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [2:0]    idx_q, idx_d;
  logic          out_q, out_d;
  logic          bit_end;

  // Counter idles at zero so the first bit period starts cleanly after accept.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (state_q == IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    in_ready = (state_q == IDLE) || (state_q == STOP && bit_end);
    state_d  = state_q;
    shift_d  = shift_q;
    par_d    = par_q;
    idx_d    = idx_q;

    case (state_q)
      START:  if (bit_end) begin state_d = DATA; idx_d = '0; end
      DATA:   if (bit_end) begin
                if (idx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
                else begin
                  idx_d   = idx_q + 1'b1;
                  shift_d = shift_q >> 1;
                end
              end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = IDLE;
      default: ;
    endcase

    if (in_valid && in_ready) begin
      state_d = START;
      shift_d = in_byte;
      par_d   = odd_parity(in_byte);
      idx_d   = '0;
    end

    // Line level follows the upcoming state so out stays a pure register.
    case (state_d)
      START:   out_d = START_LEVEL;
      DATA:    out_d = shift_d[0];
      PARITY:  out_d = par_d;
      STOP:    out_d = STOP_LEVEL;
      default: out_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      out_q   <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_odd_parity.sv
// Directed bench for the odd-parity transmitter at one and four clocks per bit.
module tb_uart_tx_odd_parity;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_byte, b_byte;
  logic       a_valid, b_valid;
  logic       a_ready, a_out, a_busy;
  logic       b_ready, b_out, b_busy;
  int         total = 0;
  int         bad = 0;
  logic [7:0] rx;

  always #5 clk = ~clk;

  uart_tx_odd_parity #(.CLKS_PER_BIT(1)) dut_a (
    .clk(clk), .reset(reset), .in_byte(a_byte), .in_valid(a_valid),
    .in_ready(a_ready), .out(a_out), .busy(a_busy)
  );

  uart_tx_odd_parity #(.CLKS_PER_BIT(4)) dut_b (
    .clk(clk), .reset(reset), .in_byte(b_byte), .in_valid(b_valid),
    .in_ready(b_ready), .out(b_out), .busy(b_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // exp lists the line bits first-to-last from MSB down; call right after the accept edge.
  task automatic frame_a(input logic [10:0] exp, input string tag, output logic [7:0] data);
    data = '0;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("%s_out%0d", tag, k), a_out, exp[10-k]);
      chk($sformatf("%s_busy%0d", tag, k), a_busy, 1'b1);
      chk($sformatf("%s_rdy%0d", tag, k), a_ready, k == 10);
      if (k >= 1 && k <= 8) data[k-1] = a_out;
      tick();
    end
  endtask

  task automatic idle_a(input string tag);
    chk({tag, "_out"},  a_out,   1'b1);
    chk({tag, "_busy"}, a_busy,  1'b0);
    chk({tag, "_rdy"},  a_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_byte = '0; b_byte = '0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle_a($sformatf("idle%0d", i));
      chk($sformatf("idle_b%0d", i), b_out, 1'b1);
      tick();
    end

    // 0x00: parity 1
    a_byte = 8'h00; a_valid = 1'b1; tick(); a_valid = 1'b0;
    frame_a(11'b00000000011, "b00", rx);
    idle_a("after00");

    // 0x80: parity 0, bench-side decode of the data bits
    a_byte = 8'h80; a_valid = 1'b1; tick(); a_valid = 1'b0;
    frame_a(11'b00000000101, "b80", rx);
    chk8("rx80", rx, 8'h80);
    idle_a("after80");

    // Back-to-back with in_valid held; byte change mid-frame must not leak in
    a_byte = 8'hA5; a_valid = 1'b1; tick(); a_byte = 8'h3C;
    frame_a(11'b01010010111, "bA5", rx);
    a_valid = 1'b0;
    frame_a(11'b00011110011, "b3C", rx);
    chk8("rx3C", rx, 8'h3C);
    idle_a("after3C");

    // Four clocks per bit, 0x01: parity 0
    b_byte = 8'h01; b_valid = 1'b1; tick(); b_valid = 1'b0; b_byte = 8'hFF;
    begin
      logic [10:0] e;
      e = 11'b01000000001;
      for (int j = 0; j < 44; j++) begin
        chk($sformatf("cpb4_out%0d", j), b_out, e[10 - j/4]);
        chk($sformatf("cpb4_busy%0d", j), b_busy, 1'b1);
        chk($sformatf("cpb4_rdy%0d", j), b_ready, j == 43);
        tick();
      end
    end
    chk("cpb4_end_busy", b_busy, 1'b0);
    chk("cpb4_end_out", b_out, 1'b1);
    chk("cpb4_end_rdy", b_ready, 1'b1);

    // Reset during data bit 3 of 0xFF
    a_byte = 8'hFF; a_valid = 1'b1; tick(); a_valid = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    chk("ff_bit3_out", a_out, 1'b1);
    chk("ff_bit3_rdy", a_ready, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    idle_a("rst_mid");
    tick();
    idle_a("rst_stay");

    // Fresh frame after the dropped one: 0x5A, parity 1
    a_byte = 8'h5A; a_valid = 1'b1; tick(); a_valid = 1'b0;
    frame_a(11'b00101101011, "b5A", rx);
    chk8("rx5A", rx, 8'h5A);
    idle_a("after5A");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
